// File: rtl/uart_byte_tx.sv
// Byte capture FIFO plus 8N1 UART transmitter for one sequencer channel.
// Each RD rising edge pushes RdData; bytes leave LSB first with no idle gap
// when the FIFO still holds data. A byte counter flags the end of each frame.
//
// state | meaning
// IDLE  | line idle high, waiting for a byte in the FIFO
// START | start bit (low) for CLKS_PER_BIT clocks
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); pops the next byte on its last clock if available
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 6,
  parameter int FIFO_DEPTH   = 4,
  parameter int FRAME_LEN    = 18
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        RD,
  input  logic [7:0]                  RdData,
  output logic                        TX,
  output logic                        busy,
  output logic                        frameDone,
  output logic                        ovf,
  output logic [$clog2(FIFO_DEPTH):0] level
);

  localparam int         AW         = $clog2(FIFO_DEPTH);
  localparam logic [7:0] BIT_LAST   = 8'(CLKS_PER_BIT - 1);
  localparam logic [4:0] FRAME_LAST = 5'(FRAME_LEN - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [7:0]    timer_q, timer_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [4:0]    byte_cnt_q, byte_cnt_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          frame_done_q, frame_done_d;

  logic          rd_prev_q;
  logic          ovf_q;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;

  logic push, push_ok, pop, full, empty, bit_last;

  // Occupancy never exceeds 2**AW, so the MSB alone marks a full FIFO.
  assign full     = level_q[AW];
  assign empty    = (level_q == '0);
  assign push     = RD & ~rd_prev_q;
  // A pop in the same clock frees a slot, so a push to a full FIFO is kept.
  assign push_ok  = push & (~full | pop);
  assign bit_last = (timer_q == BIT_LAST);

  assign TX        = tx_q;
  assign busy      = busy_q;
  assign frameDone = frame_done_q;
  assign ovf       = ovf_q;
  assign level     = level_q;

  // RD edge register, FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_prev_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      rd_prev_q <= RD;
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop)      level_q <= level_q + 1'b1;
      else if (pop && !push_ok) level_q <= level_q - 1'b1;
      if (push && !push_ok) ovf_q <= 1'b1;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= RdData;
  end

  // Transmitter state and registered line/status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      timer_q      <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_cnt_q   <= '0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_cnt_q   <= byte_cnt_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Next-state, pop decision and frame counting.
  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_cnt_d   = byte_cnt_q;
    frame_done_d = 1'b0;
    pop          = 1'b0;
    tx_d         = 1'b1;
    busy_d       = (state_q != IDLE) | (level_q != '0);

    unique case (state_q)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = mem_q[rd_ptr_q];
          timer_d = '0;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_last) begin
          timer_d   = '0;
          bit_idx_d = '0;
          state_d   = DATA;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      DATA: begin
        tx_d = shift_q[0];
        if (bit_last) begin
          timer_d   = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (bit_last) begin
          timer_d = '0;
          if (byte_cnt_q == FRAME_LAST) begin
            byte_cnt_d   = '0;
            frame_done_d = 1'b1;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
          if (!empty) begin
            pop     = 1'b1;
            shift_d = mem_q[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Directed bench for uart_byte_tx: default instance (u0) and a slow
// CLKS_PER_BIT=16 instance (u1) for back-to-back and full-FIFO cases.
module tb_uart_byte_tx;

  localparam int P0 = 6,  H0 = 3;
  localparam int P1 = 16, H1 = 8;

  logic       clk;
  logic [1:0] rst_v, rd_v, tx_v, busy_v, fd_v, ovf_v;
  logic [7:0] dat0, dat1;
  logic [2:0] lvl0, lvl1;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  uart_byte_tx #(.CLKS_PER_BIT(P0), .FIFO_DEPTH(4), .FRAME_LEN(18)) u0 (
    .clk(clk), .rst(rst_v[0]), .RD(rd_v[0]), .RdData(dat0), .TX(tx_v[0]),
    .busy(busy_v[0]), .frameDone(fd_v[0]), .ovf(ovf_v[0]), .level(lvl0));

  uart_byte_tx #(.CLKS_PER_BIT(P1), .FIFO_DEPTH(4), .FRAME_LEN(18)) u1 (
    .clk(clk), .rst(rst_v[1]), .RD(rd_v[1]), .RdData(dat1), .TX(tx_v[1]),
    .busy(busy_v[1]), .frameDone(fd_v[1]), .ovf(ovf_v[1]), .level(lvl1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Line receivers: sample mid-bit on the falling clock edge.
  logic [7:0] rxq0[$], rxq1[$];
  int         st1[$];
  logic [7:0] sh0 = '0, sh1 = '0;
  bit         act0 = 0, act1 = 0;
  int cnt0 = 0, cnt1 = 0, rx_tot0 = 0, rx_tot1 = 0, ferr0 = 0, ferr1 = 0;
  int tx_low0 = 0, fd_cnt0 = 0, fd_rx0 = 0, fd_cyc0 = 0, st_last0 = 0;

  always @(negedge clk) begin
    if (tx_v[0] == 1'b0) tx_low0 <= tx_low0 + 1;
    if (fd_v[0]) begin
      fd_cnt0 <= fd_cnt0 + 1;
      fd_rx0  <= rx_tot0;
      fd_cyc0 <= cyc - st_last0;
    end
    if (rst_v[0]) act0 <= 0;
    else if (!act0) begin
      if (!tx_v[0]) begin act0 <= 1; cnt0 <= 1; st_last0 <= cyc; end
    end else begin
      cnt0 <= cnt0 + 1;
      if ((cnt0 - H0) % P0 == 0) begin
        if (cnt0 == H0) begin
          if (tx_v[0]) ferr0 <= ferr0 + 1;
        end else if (cnt0 < H0 + 9 * P0) begin
          sh0 <= {tx_v[0], sh0[7:1]};
        end else begin
          if (!tx_v[0]) ferr0 <= ferr0 + 1;
          rxq0.push_back(sh0);
          rx_tot0 <= rx_tot0 + 1;
          act0 <= 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_v[1]) act1 <= 0;
    else if (!act1) begin
      if (!tx_v[1]) begin act1 <= 1; cnt1 <= 1; st1.push_back(cyc); end
    end else begin
      cnt1 <= cnt1 + 1;
      if ((cnt1 - H1) % P1 == 0) begin
        if (cnt1 == H1) begin
          if (tx_v[1]) ferr1 <= ferr1 + 1;
        end else if (cnt1 < H1 + 9 * P1) begin
          sh1 <= {tx_v[1], sh1[7:1]};
        end else begin
          if (!tx_v[1]) ferr1 <= ferr1 + 1;
          rxq1.push_back(sh1);
          rx_tot1 <= rx_tot1 + 1;
          act1 <= 0;
        end
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int d, input string nm);
    int w;
    w = 0;
    while (busy_v[d] && w < 2000) begin tick(); w++; end
    chk(nm, (w >= 2000) ? 1 : 0, 0);
    repeat (20) tick();
  endtask

  typedef struct {
    logic [7:0] data;
    int         hold;
    logic [7:0] exp_byte;
    int         exp_chars;
  } vec_t;

  vec_t       vt [6];
  logic [9:0] pat;
  int         base, base_fd, base_low, n, lmax;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    vt[0] = '{8'h00,  1, 8'h00, 1};
    vt[1] = '{8'hFF,  2, 8'hFF, 1};
    vt[2] = '{8'h3C, 40, 8'h3C, 1};
    vt[3] = '{8'h5A,  4, 8'h5A, 1};
    vt[4] = '{8'h81,  3, 8'h81, 1};
    vt[5] = '{8'h96,  4, 8'h96, 1};

    rst_v = 2'b11; rd_v = 2'b00; dat0 = '0; dat1 = '0;
    repeat (3) tick();
    chk("rst_tx", tx_v[0], 1);
    chk("rst_busy", busy_v[0], 0);
    chk("rst_frameDone", fd_v[0], 0);
    chk("rst_ovf", ovf_v[0], 0);
    chk("rst_level", lvl0, 0);
    rst_v = 2'b00;
    repeat (2) tick();

    // Single byte 0xA5 with exact line timing
    pat = {1'b1, 8'hA5, 1'b0};
    rd_v[0] = 1'b1; dat0 = 8'hA5;
    tick();
    chk("a5_level_peak", lvl0, 1);
    chk("a5_tx_edgeN", tx_v[0], 1);
    tick();
    chk("a5_busy_edgeN1", busy_v[0], 1);
    chk("a5_level_popped", lvl0, 0);
    chk("a5_tx_edgeN1", tx_v[0], 1);
    for (int i = 0; i < 60; i++) begin
      if (i == 2) rd_v[0] = 1'b0;
      tick();
      chk($sformatf("a5_line[%0d]", i), tx_v[0], int'(pat[i / 6]));
    end
    chk("a5_busy_last_stop", busy_v[0], 1);
    tick();
    chk("a5_busy_after_stop", busy_v[0], 0);
    chk("a5_tx_idle", tx_v[0], 1);
    repeat (5) tick();
    chk("a5_decoded", rxq0[0], 8'hA5);

    // Table of single characters with various RD hold lengths
    for (int v = 0; v < 6; v++) begin
      base = rx_tot0;
      rd_v[0] = 1'b1; dat0 = vt[v].data;
      repeat (vt[v].hold) tick();
      rd_v[0] = 1'b0;
      repeat (2) tick();
      wait_idle(0, $sformatf("vec%0d_timeout", v));
      chk($sformatf("vec%0d_chars", v), rx_tot0 - base, vt[v].exp_chars);
      if (rx_tot0 > base) chk($sformatf("vec%0d_byte", v), rxq0[base], vt[v].exp_byte);
      chk($sformatf("vec%0d_ovf", v), ovf_v[0], 0);
    end
    chk("framing_errors_u0_a", ferr0, 0);
    chk("no_frameDone_yet", fd_cnt0, 0);

    // Reset during DATA bit 3 of 0xFF with two bytes queued
    rd_v[0] = 1'b1; dat0 = 8'hFF; tick();
    rd_v[0] = 1'b0; tick();
    rd_v[0] = 1'b1; dat0 = 8'h11; tick();
    rd_v[0] = 1'b0; tick();
    rd_v[0] = 1'b1; dat0 = 8'h22; tick();
    rd_v[0] = 1'b0;
    repeat (24) tick();
    chk("midrst_level_before", lvl0, 2);
    chk("midrst_busy_before", busy_v[0], 1);
    #2 rst_v[0] = 1'b1;
    #1;
    chk("midrst_tx", tx_v[0], 1);
    chk("midrst_level", lvl0, 0);
    chk("midrst_busy", busy_v[0], 0);
    repeat (2) tick();
    rst_v[0] = 1'b0;
    base_low = tx_low0; base = rx_tot0;
    repeat (150) tick();
    chk("midrst_no_tx_low", tx_low0 - base_low, 0);
    chk("midrst_no_chars", rx_tot0 - base, 0);
    chk("midrst_level_after", lvl0, 0);

    // Two full frames at the nominal RD spacing
    for (int f = 0; f < 2; f++) begin
      base = rx_tot0; base_fd = fd_cnt0; lmax = 0;
      for (int b = 0; b < 18; b++) begin
        rd_v[0] = 1'b1; dat0 = 8'(b);
        for (int k = 0; k < 65; k++) begin
          if (k == 4) rd_v[0] = 1'b0;
          tick();
          if (int'(lvl0) > lmax) lmax = int'(lvl0);
        end
      end
      wait_idle(0, $sformatf("frame%0d_timeout", f));
      n = rx_tot0 - base;
      chk($sformatf("frame%0d_chars", f), n, 18);
      for (int b = 0; b < 18 && b < n; b++)
        chk($sformatf("frame%0d_byte%0d", f, b), rxq0[base + b], b);
      chk($sformatf("frame%0d_frameDone_count", f), fd_cnt0 - base_fd, 1);
      chk($sformatf("frame%0d_frameDone_after_byte", f), fd_rx0 - base, 18);
      chk($sformatf("frame%0d_frameDone_timing", f), fd_cyc0, 59);
      chk($sformatf("frame%0d_ovf", f), ovf_v[0], 0);
      chk($sformatf("frame%0d_level_max", f), lmax, 1);
    end
    chk("framing_errors_u0_b", ferr0, 0);

    // u1: back-to-back characters and overflow
    base = rx_tot1;
    for (int t = 0; t < 48; t++) begin
      rd_v[1] = (t % 8) < 4;
      dat1 = 8'(32'h10 + t / 8);
      tick();
      if (t == 32) begin
        chk("ovf_level_full", lvl1, 4);
        chk("ovf_flag_before", ovf_v[1], 0);
      end
      if (t == 40) begin
        chk("ovf_flag_set", ovf_v[1], 1);
        chk("ovf_level_unchanged", lvl1, 4);
      end
    end
    rd_v[1] = 1'b0;
    wait_idle(1, "ovf_timeout");
    n = rx_tot1 - base;
    chk("ovf_chars", n, 5);
    for (int b = 0; b < 5 && b < n; b++)
      chk($sformatf("ovf_byte%0d", b), rxq1[base + b], 8'h10 + b);
    for (int b = 1; b < 5 && b < n; b++)
      chk($sformatf("ovf_gap%0d", b), st1[base + b] - st1[base + b - 1], 10 * P1);
    chk("ovf_sticky", ovf_v[1], 1);

    rst_v[1] = 1'b1; tick();
    chk("u1_rst_ovf", ovf_v[1], 0);
    chk("u1_rst_level", lvl1, 0);
    rst_v[1] = 1'b0; tick();

    // u1: push to a full FIFO on the STOP->START pop clock
    base = rx_tot1;
    for (int t = 0; t <= 161; t++) begin
      rd_v[1] = ((t < 40) && ((t % 8) < 4)) || (t == 161);
      dat1 = (t < 40) ? 8'(32'h20 + t / 8) : 8'h25;
      tick();
      if (t == 160) chk("simul_level_before", lvl1, 4);
      if (t == 161) begin
        chk("simul_level_after", lvl1, 4);
        chk("simul_ovf", ovf_v[1], 0);
      end
    end
    rd_v[1] = 1'b0;
    wait_idle(1, "simul_timeout");
    n = rx_tot1 - base;
    chk("simul_chars", n, 6);
    for (int b = 0; b < 6 && b < n; b++)
      chk($sformatf("simul_byte%0d", b), rxq1[base + b], 8'h20 + b);
    for (int b = 1; b < 6 && b < n; b++)
      chk($sformatf("simul_gap%0d", b), st1[base + b] - st1[base + b - 1], 10 * P1);
    chk("simul_ovf_end", ovf_v[1], 0);
    chk("framing_errors_u1", ferr1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
